// File: rtl/i2s_tx_if.sv
// Mixer-to-I2S bus: summed sample words and strobe in, serial I2S stream and status pulses out.
interface i2s_tx_if #(
   parameter int IN_WIDTH = 19
);
   logic signed [IN_WIDTH-1:0] snd_left;
   logic signed [IN_WIDTH-1:0] snd_right;
   logic                       snd_sample;
   logic                       i2s_bclk;
   logic                       i2s_lrck;
   logic                       i2s_sdata;
   logic                       frame_start;
   logic                       underrun;
   logic                       clip;

   modport master (
      output snd_left, snd_right, snd_sample,
      input  i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, clip
   );

   modport slave (
      input  snd_left, snd_right, snd_sample,
      output i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, clip
   );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: gain/saturate captured mixer samples, serialize one stereo frame
// of 2*SLOT_BITS bit clocks; all output updates are aligned to the BCLK falling edge.
module i2s_tx #(
   parameter int IN_WIDTH   = 19,
   parameter int SLOT_BITS  = 24,
   parameter int HALF_DIV   = 9,
   parameter int GAIN_SHIFT = 0
) (
   input  logic      clk,
   input  logic      rst,
   i2s_tx_if.slave   bus
);

   localparam int FW  = 2 * SLOT_BITS;
   localparam int BW  = $clog2(FW);
   localparam int DW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int XW  = IN_WIDTH + GAIN_SHIFT;
   localparam int PAD = SLOT_BITS - IN_WIDTH;

   localparam logic signed [XW-1:0] X_MAX = {{(GAIN_SHIFT+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] X_MIN = {{(GAIN_SHIFT+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

   function automatic logic signed [XW-1:0] prescale(input logic signed [IN_WIDTH-1:0] v);
      logic signed [XW-1:0] x;
      x = XW'(v);
      return x <<< GAIN_SHIFT;
   endfunction

   function automatic logic is_sat(input logic signed [XW-1:0] x);
      return (x > X_MAX) || (x < X_MIN);
   endfunction

   function automatic logic signed [IN_WIDTH-1:0] sat_fn(input logic signed [XW-1:0] x);
      if (x > X_MAX)
         return {1'b0, {(IN_WIDTH-1){1'b1}}};
      else if (x < X_MIN)
         return {1'b1, {(IN_WIDTH-1){1'b0}}};
      else
         return x[IN_WIDTH-1:0];
   endfunction

   function automatic logic [SLOT_BITS-1:0] align_fn(input logic signed [IN_WIDTH-1:0] s);
      logic [SLOT_BITS-1:0] w;
      w = SLOT_BITS'($unsigned(s));
      return w << PAD;
   endfunction

   logic [DW-1:0]        div_q, div_d;
   logic                 bclk_q, bclk_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 lrck_q, lrck_d;
   logic                 sdata_q, sdata_d;
   logic [SLOT_BITS-1:0] holding_l_q, holding_l_d;
   logic [SLOT_BITS-1:0] holding_r_q, holding_r_d;
   logic [SLOT_BITS-1:0] shift_l_q, shift_l_d;
   logic [SLOT_BITS-1:0] shift_r_q, shift_r_d;
   logic                 fresh_q, fresh_d;
   logic                 frame_start_q, frame_start_d;
   logic                 underrun_q, underrun_d;
   logic                 clip_q, clip_d;

   logic                 fall;
   logic                 load;
   logic                 capture;
   logic signed [XW-1:0] xl, xr;
   logic [BW-1:0]        idx;
   logic [FW-1:0]        frame;

   always_comb begin
      div_d  = div_q + 1'b1;
      bclk_d = bclk_q;
      fall   = 1'b0;
      if (div_q == DW'(HALF_DIV-1)) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
         fall   = bclk_q;
      end

      bit_d = bit_q;
      if (fall)
         bit_d = (bit_q == BW'(FW-1)) ? '0 : bit_q + 1'b1;
      load = fall && (bit_d == '0);

      capture     = bus.snd_sample;
      xl          = prescale(bus.snd_left);
      xr          = prescale(bus.snd_right);
      holding_l_d = capture ? align_fn(sat_fn(xl)) : holding_l_q;
      holding_r_d = capture ? align_fn(sat_fn(xr)) : holding_r_q;

      // Load takes the pre-capture holding words; a coincident capture stays fresh for the next frame.
      shift_l_d     = load ? holding_l_q : shift_l_q;
      shift_r_d     = load ? holding_r_q : shift_r_q;
      fresh_d       = capture | (fresh_q & ~load);
      frame_start_d = load;
      underrun_d    = load & ~fresh_q;
      clip_d        = capture & (is_sat(xl) | is_sat(xr));

      lrck_d  = lrck_q;
      sdata_d = sdata_q;
      idx     = BW'(FW-1) - bit_d;
      frame   = {shift_l_d, shift_r_d};
      if (fall) begin
         lrck_d  = (bit_d >= BW'(SLOT_BITS-1)) && (bit_d < BW'(FW-1));
         sdata_d = frame[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         bclk_q        <= 1'b0;
         bit_q         <= '0;
         lrck_q        <= 1'b0;
         sdata_q       <= 1'b0;
         holding_l_q   <= '0;
         holding_r_q   <= '0;
         shift_l_q     <= '0;
         shift_r_q     <= '0;
         fresh_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         clip_q        <= 1'b0;
      end else begin
         div_q         <= div_d;
         bclk_q        <= bclk_d;
         bit_q         <= bit_d;
         lrck_q        <= lrck_d;
         sdata_q       <= sdata_d;
         holding_l_q   <= holding_l_d;
         holding_r_q   <= holding_r_d;
         shift_l_q     <= shift_l_d;
         shift_r_q     <= shift_r_d;
         fresh_q       <= fresh_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         clip_q        <= clip_d;
      end
   end

   assign bus.i2s_bclk    = bclk_q;
   assign bus.i2s_lrck    = lrck_q;
   assign bus.i2s_sdata   = sdata_q;
   assign bus.frame_start = frame_start_q;
   assign bus.underrun    = underrun_q;
   assign bus.clip        = clip_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (gain 0 and gain 2) driven by one directed stimulus,
// checked every cycle against a frame-level behavioural model plus literal frame words.
module tb_i2s_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [18:0] snd_left = '0;
   logic [18:0] snd_right = '0;
   logic        snd_sample = 1'b0;

   int vectors = 0;
   int fails   = 0;
   int cyc     = 0;

   i2s_tx_if #(.IN_WIDTH(19)) if0 ();
   i2s_tx_if #(.IN_WIDTH(19)) if2 ();

   assign if0.snd_left   = snd_left;
   assign if0.snd_right  = snd_right;
   assign if0.snd_sample = snd_sample;
   assign if2.snd_left   = snd_left;
   assign if2.snd_right  = snd_right;
   assign if2.snd_sample = snd_sample;

   i2s_tx #(.IN_WIDTH(19), .SLOT_BITS(24), .HALF_DIV(9), .GAIN_SHIFT(0)) dut0 (
      .clk (clk), .rst (rst), .bus (if0));
   i2s_tx #(.IN_WIDTH(19), .SLOT_BITS(24), .HALF_DIV(9), .GAIN_SHIFT(2)) dut2 (
      .clk (clk), .rst (rst), .bus (if2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: n = clk edges since reset release; BCLK, slot index and frame
   // boundaries follow from n by plain division, words from integer scaling and clamping.
   longint      n = 0;
   logic [23:0] hl [2] = '{default: '0};
   logic [23:0] hr [2] = '{default: '0};
   logic [23:0] cl [2] = '{default: '0};
   logic [23:0] cr [2] = '{default: '0};
   bit          fr [2] = '{default: 1'b0};
   bit          efs[2] = '{default: 1'b0};
   bit          eur[2] = '{default: 1'b0};
   bit          ecl[2] = '{default: 1'b0};
   int          gain[2] = '{0, 2};

   function automatic logic [23:0] mword(input logic [18:0] v, input int g, output bit s);
      longint x;
      x = longint'($signed(v)) * (longint'(1) << g);
      s = 1'b0;
      if (x > 262143) begin
         x = 262143;
         s = 1'b1;
      end else if (x < -262144) begin
         x = -262144;
         s = 1'b1;
      end
      return 24'(x * 32);
   endfunction

   always @(posedge clk) begin
      bit ld, sl, sr;
      logic [23:0] wl, wr;
      if (rst) begin
         n = 0;
         for (int i = 0; i < 2; i++) begin
            hl[i] = '0; hr[i] = '0; cl[i] = '0; cr[i] = '0;
            fr[i] = 1'b0; efs[i] = 1'b0; eur[i] = 1'b0; ecl[i] = 1'b0;
         end
      end else begin
         n++;
         ld = (n % 864 == 0);
         for (int i = 0; i < 2; i++) begin
            efs[i] = ld;
            eur[i] = ld && !fr[i];
            if (ld) begin
               cl[i] = hl[i];
               cr[i] = hr[i];
            end
            ecl[i] = 1'b0;
            if (snd_sample) begin
               wl = mword(snd_left, gain[i], sl);
               wr = mword(snd_right, gain[i], sr);
               hl[i] = wl;
               hr[i] = wr;
               fr[i] = 1'b1;
               ecl[i] = sl | sr;
            end else if (ld) begin
               fr[i] = 1'b0;
            end
         end
      end
   end

   function automatic logic [5:0] exp_vec(input int i);
      int   k;
      logic b, lr, sd;
      k  = int'((n / 18) % 48);
      b  = ((n / 9) % 2) == 1;
      lr = (k >= 23) && (k < 47);
      sd = (k < 24) ? cl[i][23-k] : cr[i][47-k];
      return {b, lr, sd, efs[i], eur[i], ecl[i]};
   endfunction

   always @(negedge clk) begin
      logic [5:0] a0, a2, e0, e2;
      a0 = {if0.i2s_bclk, if0.i2s_lrck, if0.i2s_sdata, if0.frame_start, if0.underrun, if0.clip};
      a2 = {if2.i2s_bclk, if2.i2s_lrck, if2.i2s_sdata, if2.frame_start, if2.underrun, if2.clip};
      e0 = exp_vec(0);
      e2 = exp_vec(1);
      vectors++;
      if (a0 !== e0) begin
         fails++;
         $display("FAIL model_g0 cyc=%0d {bclk,lrck,sdata,fs,ur,clip} got=%b want=%b", cyc, a0, e0);
      end
      vectors++;
      if (a2 !== e2) begin
         fails++;
         $display("FAIL model_g2 cyc=%0d {bclk,lrck,sdata,fs,ur,clip} got=%b want=%b", cyc, a2, e2);
      end
   end

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      fails++;
      $display("FAIL %s: timeout waiting for DUT event", nm);
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic cap(input logic [18:0] l, input logic [18:0] r);
      snd_left   = l;
      snd_right  = r;
      snd_sample = 1'b1;
      @(negedge clk);
      snd_sample = 1'b0;
   endtask

   task automatic wait_fs();
      int c = 0;
      while (!if0.frame_start && c < 2000) begin
         @(negedge clk);
         c++;
      end
      if (c >= 2000) timeout("wait_frame_start");
   endtask

   task automatic wait_bclk(input logic v);
      int c = 0;
      while (if0.i2s_bclk !== v && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) timeout("wait_bclk");
   endtask

   // Collect one frame sampled at BCLK rising edges; returns on the next frame_start cycle.
   task automatic grab(output logic [47:0] f0, output logic [47:0] f2, output logic [47:0] lr);
      f0 = '0; f2 = '0; lr = '0;
      for (int b = 0; b < 48; b++) begin
         wait_bclk(1'b1);
         f0 = {f0[46:0], if0.i2s_sdata};
         f2 = {f2[46:0], if2.i2s_sdata};
         lr = {lr[46:0], if0.i2s_lrck};
         wait_bclk(1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] f0, f2, lr;
      int rel, cnt, t_fs;

      rst = 1'b1;
      tick(10);
      chk("reset_outputs",
          {if0.i2s_bclk, if0.i2s_lrck, if0.i2s_sdata, if0.frame_start, if0.underrun, if0.clip,
           if2.i2s_bclk, if2.i2s_lrck, if2.i2s_sdata, if2.frame_start, if2.underrun, if2.clip}, 0);

      rst = 1'b0;
      rel = cyc;
      cnt = 0;
      while (if0.i2s_bclk == 1'b0 && cnt < 50) begin
         tick(1);
         cnt++;
      end
      chk("first_bclk_rise", cnt, 9);

      // Serialization
      cap(19'h12345, 19'h7FFFF);
      wait_fs();
      chk("first_frame_time", cyc - rel, 864);
      chk("first_frame_underrun", if0.underrun, 0);
      t_fs = cyc;
      grab(f0, f2, lr);
      chk("ser_words_g0", f0, {24'h2468A0, 24'hFFFFE0});
      chk("ser_words_g2", f2, {24'h7FFFE0, 24'hFFFF80});
      chk("lrck_pattern", lr, 48'h000001FFFFFE);
      chk("frame_interval", cyc - t_fs, 864);
      chk("frame_start_after_grab", if0.frame_start, 1);
      chk("underrun_no_capture", if0.underrun, 1);

      // Saturation
      cap(19'h10000, 19'h40000);
      chk("clip_g2_pulse", if2.clip, 1);
      chk("clip_g0_quiet", if0.clip, 0);
      tick(1);
      chk("clip_g2_single", if2.clip, 0);
      wait_fs();
      chk("sat_frame_underrun", if2.underrun, 0);
      grab(f0, f2, lr);
      chk("sat_words_g2", f2, {24'h7FFFE0, 24'h800000});
      chk("sat_words_g0", f0, {24'h200000, 24'h800000});

      // Underrun: no capture, words repeat
      chk("underrun_pulse", {if0.frame_start, if0.underrun}, 2'b11);
      grab(f0, f2, lr);
      chk("underrun_repeat_g2", f2, {24'h7FFFE0, 24'h800000});
      chk("underrun_again", if2.underrun, 1);
      cap(19'h00001, 19'h7FFFE);
      wait_fs();
      chk("underrun_cleared", {if0.frame_start, if0.underrun}, 2'b10);

      // Capture coinciding with the load edge
      cap(19'h0ABCD, 19'h54321);
      tick(862);
      cap(19'h3C3C3, 19'h01234);
      chk("coincident_load", {if0.frame_start, if0.underrun}, 2'b10);
      grab(f0, f2, lr);
      chk("coincident_old_words", f0, {24'h1579A0, 24'hA86420});
      chk("coincident_next_load", {if0.frame_start, if0.underrun}, 2'b10);
      grab(f0, f2, lr);
      chk("coincident_new_words", f0, {24'h787860, 24'h024680});

      // Reset mid-frame at bit_cnt = 30
      tick(540);
      rst = 1'b1;
      tick(1);
      chk("midreset_outputs",
          {if0.i2s_bclk, if0.i2s_lrck, if0.i2s_sdata, if0.frame_start, if0.underrun, if0.clip,
           if2.i2s_bclk, if2.i2s_lrck, if2.i2s_sdata, if2.frame_start, if2.underrun, if2.clip}, 0);
      rst = 1'b0;
      rel = cyc;
      tick(1);
      wait_fs();
      chk("midreset_frame_time", cyc - rel, 864);
      chk("midreset_underrun", if0.underrun, 1);
      grab(f0, f2, lr);
      chk("midreset_zero_words", f0, 48'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
